or1k_marocchino_rat_array: RTL
==============================

OR1K_MAROCCHINO_RAT_ARRAY -- requirements
Module: or1k_marocchino_rat_array

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- OPTION_RF_ADDR_WIDTH, 5, GPR address width; table depth = 2^OPTION_RF_ADDR_WIDTH entries.
- DEST_EXTADR_WIDTH, 3, allocation-ID width.
- NUM_DEST, 2, destination (write) ports per instruction, 1..4.
- NUM_SRC, 3, source-operand lookup ports, 1..4.
- R0_ALLOC, 0, 0 = GPR 0 is never allocated; 1 = GPR 0 is treated like any other entry.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- cpu_clk, in, 1, single clock; all state updates on its rising edge.
- cpu_rst_n, in, 1, asynchronous active-low reset.
- padv_exec_i, in, 1, EXECUTE advance; qualifies allocation.
- padv_wrbk_i, in, 1, WriteBack advance; qualifies release.
- pipeline_flush_i, in, 1, synchronous flush.
- dcod_rfd_we_i, in, NUM_DEST, per-port destination write enable.
- dcod_rfd_adr_i, in, NUM_DEST*OPTION_RF_ADDR_WIDTH, per-port destination GPR address; port d occupies slice d.
- dcod_extadr_i, in, DEST_EXTADR_WIDTH, allocation ID of the decoded instruction.
- exec_extadr_i, in, DEST_EXTADR_WIDTH, ID being written back.
- src_adr_i, in, NUM_SRC*OPTION_RF_ADDR_WIDTH, source GPR addresses.
- src_alloc_o, out, NUM_SRC*NUM_DEST, for source s, bit d = the addressed GPR is allocated by destination port d.
- src_extadr_o, out, NUM_SRC*DEST_EXTADR_WIDTH, allocation ID of the addressed GPR.
- alloc_cnt_o, out, OPTION_RF_ADDR_WIDTH+1, number of GPRs with any allocation flag set.
- rat_empty_o, out, 1, high when alloc_cnt_o == 0.

Function
REQ-003 Each entry g SHALL hold NUM_DEST allocation flags alloc[g][d] and one ID ext[g].
REQ-004 set[g][d] SHALL be dcod_rfd_we_i[d] & (dcod_rfd_adr_i slice d == g), forced to 0 for g == 0 when R0_ALLOC == 0; set_any[g] SHALL be the OR of set[g][*].
REQ-005 keep[g] SHALL be (ext[g] != exec_extadr_i).
REQ-006 Flag next state by {padv_wrbk_i, padv_exec_i}:
- 00: hold.
- 01: set_any[g] ? set[g][d] : alloc[g][d].
- 10: alloc[g][d] & keep[g].
- 11: set_any[g] ? set[g][d] : alloc[g][d] & keep[g]. New allocation wins over same-cycle release.
REQ-007 Several ports targeting the same GPR in one cycle SHALL set all of the matching flags for that entry.
REQ-008 ext[g] SHALL load dcod_extadr_i when padv_exec_i & set_any[g]; it SHALL hold otherwise, including during a flush.
REQ-009 pipeline_flush_i SHALL clear all flags on the next edge and take priority over REQ-006; ext[] is unaffected.
REQ-010 Lookups SHALL be combinational from registered state, with no same-cycle bypass of decode allocations: src_alloc_o/src_extadr_o for source s = alloc[a][*]/ext[a], where a = src_adr_i slice s.
REQ-011 With R0_ALLOC == 0, a lookup of GPR 0 SHALL return all-zero flags and all-zero ID.
REQ-012 alloc_cnt_o SHALL be registered and, after every edge, equal the popcount over g of (OR of alloc[g][*]) in the new state; rat_empty_o SHALL be registered consistently with it.
REQ-013 The counter SHALL never wrap: its maximum is 2^OPTION_RF_ADDR_WIDTH, or that value minus 1 when R0_ALLOC == 0.

Reset
REQ-014 cpu_rst_n low SHALL immediately (asynchronously) clear all flags, set ext[] = 0, alloc_cnt_o = 0 and rat_empty_o = 1, independent of cpu_clk.
REQ-015 Deassertion of cpu_rst_n SHALL be synchronised outside this block; the first edge after release SHALL obey REQ-006 normally.
REQ-016 Reset asserted mid-operation SHALL discard all allocations, with no partial-release behaviour.

Verification
REQ-017 Port 0 allocates r5 with ID 3, padv_exec=1 -> next cycle src lookup r5 gives alloc={d0=1,d1=0}, ext=3, cnt=1, empty=0.
REQ-018 Then padv_wrbk=1, exec_extadr=3 -> r5 flags clear, cnt=0, empty=1; with exec_extadr=2 instead -> r5 stays allocated.
REQ-019 Same cycle: padv_exec & padv_wrbk, re-allocate r5 with ID 4 while exec_extadr=3 -> r5 allocated, ext=4, cnt=1.
REQ-020 Ports 0 and 1 both target r7 with ID 1 -> r7 alloc={1,1}, cnt=1; a write to r0 with R0_ALLOC=0 -> r0 lookup all zero, cnt unchanged.
REQ-021 Allocate r1..r31, then pipeline_flush_i with padv_exec=1 -> all flags 0, cnt=0, ext[] retains the prior IDs.
REQ-022 cpu_rst_n pulsed low between clock edges with entries allocated -> outputs zero and empty=1 before the next edge.

Source files
------------

// File: rtl/or1k_marocchino_rat_array_if.sv
// Register-allocation-table bundle: decode/exec/writeback controls in,
// per-source allocation lookups and occupancy out.
interface or1k_marocchino_rat_array_if #(
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int DEST_EXTADR_WIDTH    = 3,
  parameter int NUM_DEST             = 2,
  parameter int NUM_SRC              = 3
);
  logic                                     padv_exec_i;
  logic                                     padv_wrbk_i;
  logic                                     pipeline_flush_i;
  logic [NUM_DEST-1:0]                      dcod_rfd_we_i;
  logic [NUM_DEST*OPTION_RF_ADDR_WIDTH-1:0] dcod_rfd_adr_i;
  logic [DEST_EXTADR_WIDTH-1:0]             dcod_extadr_i;
  logic [DEST_EXTADR_WIDTH-1:0]             exec_extadr_i;
  logic [NUM_SRC*OPTION_RF_ADDR_WIDTH-1:0]  src_adr_i;
  logic [NUM_SRC*NUM_DEST-1:0]              src_alloc_o;
  logic [NUM_SRC*DEST_EXTADR_WIDTH-1:0]     src_extadr_o;
  logic [OPTION_RF_ADDR_WIDTH:0]            alloc_cnt_o;
  logic                                     rat_empty_o;

  modport master (
    output padv_exec_i, padv_wrbk_i, pipeline_flush_i,
    output dcod_rfd_we_i, dcod_rfd_adr_i, dcod_extadr_i, exec_extadr_i, src_adr_i,
    input  src_alloc_o, src_extadr_o, alloc_cnt_o, rat_empty_o
  );

  modport slave (
    input  padv_exec_i, padv_wrbk_i, pipeline_flush_i,
    input  dcod_rfd_we_i, dcod_rfd_adr_i, dcod_extadr_i, exec_extadr_i, src_adr_i,
    output src_alloc_o, src_extadr_o, alloc_cnt_o, rat_empty_o
  );
endinterface

// File: rtl/or1k_marocchino_rat_array.sv
// Register allocation table: tracks which GPRs await a result, from which
// destination port and under which allocation ID.
module or1k_marocchino_rat_array #(
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int DEST_EXTADR_WIDTH    = 3,
  parameter int NUM_DEST             = 2,
  parameter int NUM_SRC              = 3,
  parameter int R0_ALLOC             = 0
) (
  input logic                        cpu_clk,
  input logic                        cpu_rst_n,
  or1k_marocchino_rat_array_if.slave rat
);
  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int EW = DEST_EXTADR_WIDTH;
  localparam int ND = NUM_DEST;
  localparam int NG = 1 << AW;
  localparam int CW = AW + 1;

  logic [NG-1:0][ND-1:0] alloc_reg;
  logic [NG-1:0][ND-1:0] alloc_next;
  logic [NG-1:0][ND-1:0] set_mtx;
  logic [EW-1:0]         ext_reg [NG];
  logic [NG-1:0]         set_any;
  logic [NG-1:0]         keep;
  logic [NG-1:0]         busy_next;
  logic [CW-1:0]         cnt_reg;
  logic [CW-1:0]         cnt_next;
  logic                  empty_reg;

  for (genvar gi = 0; gi < NG; gi++) begin : g_entry
    localparam bit R0_BLOCK = (R0_ALLOC == 0) && (gi == 0);
    for (genvar di = 0; di < ND; di++) begin : g_dest
      assign set_mtx[gi][di] = !R0_BLOCK && rat.dcod_rfd_we_i[di] &&
                               (rat.dcod_rfd_adr_i[di*AW +: AW] == AW'(gi));
    end
    assign set_any[gi]   = |set_mtx[gi];
    assign keep[gi]      = (ext_reg[gi] != rat.exec_extadr_i);
    assign busy_next[gi] = |alloc_next[gi];
  end

  // A new allocation overrides a same-cycle release of the same entry.
  always_comb begin
    alloc_next = alloc_reg;
    for (int g = 0; g < NG; g++) begin
      if (rat.pipeline_flush_i) begin
        alloc_next[g] = '0;
      end else begin
        case ({rat.padv_wrbk_i, rat.padv_exec_i})
          2'b01:   if (set_any[g]) alloc_next[g] = set_mtx[g];
          2'b10:   if (!keep[g]) alloc_next[g] = '0;
          2'b11:   alloc_next[g] = set_any[g] ? set_mtx[g] : (keep[g] ? alloc_reg[g] : '0);
          default: alloc_next[g] = alloc_reg[g];
        endcase
      end
    end
  end

  assign cnt_next = CW'($countones(busy_next));

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      alloc_reg <= '0;
      for (int g = 0; g < NG; g++) ext_reg[g] <= '0;
      cnt_reg   <= '0;
      empty_reg <= 1'b1;
    end else begin
      alloc_reg <= alloc_next;
      // IDs are written on allocation even when a flush drops the flags.
      for (int g = 0; g < NG; g++) begin
        if (rat.padv_exec_i && set_any[g]) ext_reg[g] <= rat.dcod_extadr_i;
      end
      cnt_reg   <= cnt_next;
      empty_reg <= (cnt_next == '0);
    end
  end

  for (genvar si = 0; si < NUM_SRC; si++) begin : g_src
    logic [AW-1:0] src_a;
    logic          r0_hit;
    assign src_a  = rat.src_adr_i[si*AW +: AW];
    assign r0_hit = (R0_ALLOC == 0) && (src_a == '0);
    assign rat.src_alloc_o[si*ND +: ND]  = r0_hit ? '0 : alloc_reg[src_a];
    assign rat.src_extadr_o[si*EW +: EW] = r0_hit ? '0 : ext_reg[src_a];
  end

  assign rat.alloc_cnt_o = cnt_reg;
  assign rat.rat_empty_o = empty_reg;
endmodule
